xbus_link: RTL and testbench

- Point-to-point XBus channel between the x-port of one MC3999 register file (endpoint A) and one x-port of another (endpoint B).
- Consumes each endpoint's x_out / x_write_out / x_read_out.
- Produces each endpoint's x_in / x_write_in / x_read_in.
- Emulates blocking XBus semantics: a write completes only when the other side reads it. One holding slot per direction.

---
 rtl/xbus_link.sv | 123 ++++++++++++
 tb/tb_xbus_link.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/xbus_link.sv
// Two-direction blocking XBus channel with one holding slot per direction.
// Optional deadlock watchdog is enabled with `define XBUS_DEADLOCK_EN.
module xbus_link #(
  parameter int WIDTH          = 11,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_dat_in,
  input  logic             a_write_req,
  input  logic             a_read_req,
  output logic [WIDTH-1:0] a_dat_out,
  output logic             a_write_in,
  output logic             a_read_in,
  input  logic [WIDTH-1:0] b_dat_in,
  input  logic             b_write_req,
  input  logic             b_read_req,
  output logic [WIDTH-1:0] b_dat_out,
  output logic             b_write_in,
  output logic             b_read_in,
  output logic             deadlock
);

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    ACK,
    DROP
  } st_e;

  st_e              st_q   [2];
  st_e              st_d   [2];
  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr     [2];
  logic             rd     [2];
  logic [WIDTH-1:0] din    [2];

  // Engine 0 carries A->B, engine 1 carries B->A.
  assign wr[0]  = a_write_req;
  assign wr[1]  = b_write_req;
  assign rd[0]  = b_read_req;
  assign rd[1]  = a_read_req;
  assign din[0] = a_dat_in;
  assign din[1] = b_dat_in;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      slot_d[i] = slot_q[i];
      unique case (st_q[i])
        IDLE: begin
          if (wr[i]) begin
            st_d[i]   = FULL;
            slot_d[i] = din[i];
          end
        end
        FULL: begin
          if (rd[i]) st_d[i] = ACK;
        end
        ACK: begin
          st_d[i] = wr[i] ? DROP : IDLE;
        end
        DROP: begin
          if (!wr[i]) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= IDLE;
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign b_write_in = (st_q[0] == FULL);
  assign b_dat_out  = b_write_in ? slot_q[0] : '0;
  assign a_read_in  = (st_q[0] == ACK);
  assign a_write_in = (st_q[1] == FULL);
  assign a_dat_out  = a_write_in ? slot_q[1] : '0;
  assign b_read_in  = (st_q[1] == ACK);

`ifdef XBUS_DEADLOCK_EN
  localparam logic [9:0] TO_L = 10'(TIMEOUT_CYCLES);

  logic [9:0] cnt_q;
  logic [9:0] cnt_d;
  logic       blk_a;
  logic       blk_b;

  always_comb begin
    blk_a = (a_write_req && !(st_q[0] inside {ACK, DROP}))
         || (a_read_req && (st_q[1] != FULL));
    blk_b = (b_write_req && !(st_q[1] inside {ACK, DROP}))
         || (b_read_req && (st_q[0] != FULL));
    cnt_d = cnt_q;
    if ((st_q[0] == ACK) || (st_q[1] == ACK) || !(blk_a && blk_b))
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign deadlock = (cnt_q >= TO_L);
`else
  assign deadlock = 1'b0;
`endif

endmodule

// File: tb/tb_xbus_link.sv
// Scoreboard bench for xbus_link: directed scenarios then random traffic.
// Reference model tracks words owed per direction and ack timing.
module tb_xbus_link;
  localparam int W  = 11;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_dat_in, b_dat_in;
  logic         a_write_req, a_read_req;
  logic         b_write_req, b_read_req;
  logic [W-1:0] a_dat_out, b_dat_out;
  logic         a_write_in, a_read_in;
  logic         b_write_in, b_read_in;
  logic         deadlock;

  xbus_link #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .a_dat_in(a_dat_in), .a_write_req(a_write_req),
    .a_read_req(a_read_req), .a_dat_out(a_dat_out),
    .a_write_in(a_write_in), .a_read_in(a_read_in),
    .b_dat_in(b_dat_in), .b_write_req(b_write_req),
    .b_read_req(b_read_req), .b_dat_out(b_dat_out),
    .b_write_in(b_write_in), .b_read_in(b_read_in),
    .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: words owed to each reader, when the writer's ack is due,
  // and whether the writer has released its request since the last ack.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  bit  held  [2];
  bit  armed [2];
  int  ack_at[2];
  int  now     = 0;
  int  dl_cnt  = 0;
  bit  started = 0;
  int  xfer  [2];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit wr[2], rd[2], ackc[2], ba, bb;
    logic [W-1:0] din[2];
    wr[0] = a_write_req; wr[1] = b_write_req;
    rd[0] = b_read_req;  rd[1] = a_read_req;
    din[0] = a_dat_in;   din[1] = b_dat_in;
    if (reset) begin
      started = 1;
      exp_q0.delete();
      exp_q1.delete();
      dl_cnt = 0;
      for (int d = 0; d < 2; d++) begin
        held[d] = 0; armed[d] = 1; ack_at[d] = -100;
      end
    end else begin
      for (int d = 0; d < 2; d++) ackc[d] = (now == ack_at[d]);
      ba = (wr[0] && !(ackc[0] || !armed[0])) || (rd[1] && !held[1]);
      bb = (wr[1] && !(ackc[1] || !armed[1])) || (rd[0] && !held[0]);
      if (ackc[0] || ackc[1] || !(ba && bb)) dl_cnt = 0;
      else if (dl_cnt < 1023) dl_cnt++;
      for (int d = 0; d < 2; d++) begin
        if (ackc[d]) armed[d] = !wr[d];
        else if (held[d]) begin
          if (rd[d]) begin held[d] = 0; ack_at[d] = now + 1; end
        end else if (!armed[d]) begin
          if (!wr[d]) armed[d] = 1;
        end else if (wr[d]) begin
          held[d] = 1;
          if (d == 0) exp_q0.push_back(din[d]);
          else        exp_q1.push_back(din[d]);
        end
      end
    end
    now++;
  end

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    bit exp_dl;
    if (started) begin
      chk("ab_write_in", W'(b_write_in), W'(held[0]));
      chk("ab_read_in", W'(a_read_in), W'(now == ack_at[0]));
      chk("ba_write_in", W'(a_write_in), W'(held[1]));
      chk("ba_read_in", W'(b_read_in), W'(now == ack_at[1]));
      if (b_write_in) begin
        if (exp_q0.size() == 0) begin
          chk("ab_unexpected", W'(b_write_in), W'(0));
        end else if (b_read_req) begin
          e = exp_q0.pop_front();
          chk("ab_data", b_dat_out, e);
          xfer[0]++;
        end else chk("ab_hold", b_dat_out, exp_q0[0]);
      end else chk("ab_dat_zero", b_dat_out, W'(0));
      if (a_write_in) begin
        if (exp_q1.size() == 0) begin
          chk("ba_unexpected", W'(a_write_in), W'(0));
        end else if (a_read_req) begin
          e = exp_q1.pop_front();
          chk("ba_data", a_dat_out, e);
          xfer[1]++;
        end else chk("ba_hold", a_dat_out, exp_q1[0]);
      end else chk("ba_dat_zero", a_dat_out, W'(0));
`ifdef XBUS_DEADLOCK_EN
      exp_dl = (dl_cnt >= TO);
`else
      exp_dl = 0;
`endif
      chk("deadlock", W'(deadlock), W'(exp_dl));
    end
  end

  task automatic drive(input bit aw, input logic [W-1:0] ad, input bit ar,
                       input bit bw, input logic [W-1:0] bd, input bit br,
                       input bit rst);
    @(posedge clk);
    #2;
    a_write_req = aw; a_dat_in = ad; a_read_req = ar;
    b_write_req = bw; b_dat_in = bd; b_read_req = br;
    reset = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    int x0, x1, pw, pr;
    xfer[0] = 0; xfer[1] = 0;
    reset = 1;
    a_write_req = 0; a_read_req = 0; a_dat_in = 0;
    b_write_req = 0; b_read_req = 0; b_dat_in = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    x0 = xfer[0];
    drive(1, 11'h155, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    @(negedge clk);
    chk("basic_count", W'(xfer[0] - x0), W'(1));

    x0 = xfer[0];
    drive(1, 11'h007, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(1, 11'h007, 0, 0, 0, 1, 0);
    drive(0, 11'h007, 0, 0, 0, 1, 0);
    drive(0, 11'h007, 0, 0, 0, 1, 0);
    drive(1, 11'h008, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);
    idle(2);
    @(negedge clk);
    chk("held_count", W'(xfer[0] - x0), W'(2));

    x0 = xfer[0];
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 11'h3FF, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);
    idle(2);
    @(negedge clk);
    chk("rdfirst_count", W'(xfer[0] - x0), W'(1));

    x0 = xfer[0]; x1 = xfer[1];
    drive(1, 11'h001, 0, 1, 11'h002, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 1, 0);
    idle(2);
    @(negedge clk);
    chk("cross_ab", W'(xfer[0] - x0), W'(1));
    chk("cross_ba", W'(xfer[1] - x1), W'(1));

    x0 = xfer[0];
    drive(1, 11'h0AA, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);
    idle(2);
    @(negedge clk);
    chk("reset_count", W'(xfer[0] - x0), W'(0));

    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0, 1, 0);
    drive(1, 11'h005, 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);

    pw = 50; pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pw = int'($urandom_range(90, 10));
        pr = int'($urandom_range(90, 10));
      end
      drive(($urandom % 100) < pw, W'($urandom), ($urandom % 100) < pr,
            ($urandom % 100) < pw, W'($urandom), ($urandom % 100) < pr,
            ($urandom % 300) == 0);
    end
    idle(4);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
